trap_ctrl: RTL
==============

# trap_ctrl

Machine-mode trap sequencer between the writeback stage and the CSR file. It arbitrates the CSR file's single write port between ordinary writeback CSR writes and its own multi-cycle trap-entry writes (mepc, mcause, mtval). It drives the mstatus interrupt-enable clear/set strobes, stalls the pipeline while sequencing, and issues a flush plus PC redirect to the trap vector or to mepc on mret.

## Interface
Parameters:
- XLEN, 64, data/address width
- IRQ_CODE, 7, mcause code used for the external/timer interrupt

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- exc_valid  in  1  WB instruction raised an exception
- exc_code  in  4  exception cause code
- exc_pc  in  XLEN  PC of faulting instruction
- exc_tval  in  XLEN  trap value
- irq_pending  in  1  interrupt request, level
- mret_valid  in  1  WB instruction is mret
- retire  in  1  WB instruction completes this cycle
- mstatus_ie  in  1  current mstatus.MIE from the CSR file
- mtvec  in  XLEN  current mtvec
- mepc  in  XLEN  current mepc
- wb_csr_we  in  1  WB CSR write request
- wb_csr_waddr  in  12  WB CSR address
- wb_csr_wdata  in  XLEN  WB CSR data
- csr_we  out  1  CSR file write enable
- csr_waddr  out  12  CSR file write address
- csr_wdata  out  XLEN  CSR file write data
- mstatus_ie_clear  out  1  one-cycle pulse; CSR file sets PIE←IE, IE←0
- mstatus_ie_set  out  1  one-cycle pulse; CSR file sets IE←PIE, PIE←1
- instret_incr  out  1  instruction retired, with no trap taken this cycle
- stall  out  1  freeze IF..WB
- flush  out  1  one-cycle pulse; kill all in-flight instructions
- redirect_valid  out  1  one-cycle pulse; the redirect PC is valid
- redirect_pc  out  XLEN  next fetch PC

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, REDIRECT, MRET.
- Priority in IDLE: exc_valid, then irq_take, then mret_valid.
  - irq_take = irq_pending & mstatus_ie.
- Taking an exception or interrupt:
  - Latch pc, cause and tval into internal registers.
  - For an interrupt, latch pc = exc_pc of the current WB instruction, tval = 0, cause = {1'b1, 59'b0, IRQ_CODE[3:0]}.
  - For an exception, cause = {60'b0, exc_code}.
  - Go to W_EPC.
- W_EPC: csr_we=1, addr=CSR_MEPC_ADDR (0x341), data=pc & ~3. Go to W_CAUSE.
- W_CAUSE: csr_we=1, addr=CSR_MCAUSE_ADDR (0x342), data=cause. Go to W_TVAL.
- W_TVAL: csr_we=1, addr=CSR_MTVAL_ADDR (0x343), data=tval; mstatus_ie_clear=1. Go to REDIRECT.
- REDIRECT: flush=1, redirect_valid=1. Go to IDLE.
  - redirect_pc = {mtvec[63:2], 2'b00}.
  - If mtvec[1:0]==2'b01 and the cause is an interrupt, add 4*cause[3:0].
- mret in IDLE: go to MRET.
- MRET: mstatus_ie_set=1, flush=1, redirect_valid=1, redirect_pc=mepc. Go to IDLE.
- WB passthrough: in IDLE with no trap or mret accepted, csr_we/waddr/wdata = wb_csr_*.
- An accepted exception suppresses that cycle's wb_csr_we; an accepted interrupt suppresses it too.
- instret_incr = retire & ~exc_valid & ~irq_take, and is 0 outside IDLE.
- mret counts as retired.

## Timing
- All sequencing outputs are Moore, decoded from the state register; there are no output registers.
- Exception accepted in cycle T:
  - T: stall=1, combinational from the accept condition; csr_we=0.
  - T+1: mepc write.
  - T+2: mcause write.
  - T+3: mtval write and mstatus_ie_clear.
  - T+4: flush and redirect.
  - T+5: IDLE, stall=0.
- mret accepted in T:
  - T: stall=1.
  - T+1: set, flush and redirect.
  - T+2: IDLE.
- stall = (state != IDLE) | accept.
- exc_valid, irq_pending and mret_valid are ignored outside IDLE.
- The irq request stays level; it is re-evaluated only in IDLE. After the trap it is masked, because MIE=0.
- mepc is sampled in MRET, i.e. after any WB write to mepc in an earlier cycle.
- Reset: state=IDLE and all latched registers 0.
  - Every output is 0 while rst=1, including the passthrough path.
  - Reset mid-sequence abandons it; no partial write completes after rst rises.

## Structure
- Shared parameter file gains:
  - CSR_MEPC_ADDR, CSR_MCAUSE_ADDR, CSR_MTVAL_ADDR.
  - MTVEC mode constants MTVEC_DIRECT=2'b00 and MTVEC_VECTORED=2'b01.
  - typedef enum trap_state_t.
- One sub-module: trap_vec, combinational; mtvec, cause → redirect_pc.

## Test plan
- Exception: exc_valid=1, exc_code=2, exc_pc=0x8000_0106, exc_tval=0xDEAD, mtvec=0x8000_1000.
  - Writes in order: 0x341←0x8000_0104, 0x342←2, 0x343←0xDEAD.
  - mstatus_ie_clear pulses at T+3; redirect 0x8000_1000 at T+4; stall is high for exactly 5 cycles.
- Vectored interrupt: irq_pending=1, mstatus_ie=1, mtvec=0x8000_1001.
  - mcause=0x8000_0000_0000_0007, mtval=0.
  - redirect_pc=0x8000_101C.
- Masked interrupt: irq_pending=1, mstatus_ie=0.
  - No trap and stall=0; WB writes and instret_incr pass through.
- mret: mepc=0x8000_0200.
  - T+1 shows mstatus_ie_set=1, flush=1, redirect_pc=0x8000_0200; back in IDLE at T+2.
- Collision: exc_valid and wb_csr_we (0x300) in the same cycle.
  - The WB write is dropped and instret_incr=0.
  - wb_csr_we alone in the next IDLE cycle passes through unchanged.
- Reset mid-op: assert rst at T+2 of an exception.
  - csr_we=0 and no mstatus_ie_clear or redirect afterwards; IDLE once rst is released.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode trap sequencer.
// CSR addresses, mtvec mode encodings and the sequencer state encoding.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MEPC_ADDR   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE_ADDR = 12'h342;
  localparam logic [11:0] CSR_MTVAL_ADDR  = 12'h343;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_EPC,
    ST_W_CAUSE,
    ST_W_TVAL,
    ST_REDIRECT,
    ST_MRET
  } trap_state_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR-file side of the trap sequencer: the single write port, the mstatus
// interrupt-enable strobes and the CSR values the sequencer reads back.
interface trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            mstatus_ie_clear;
  logic            mstatus_ie_set;
  logic            mstatus_ie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;

  modport master (
    output csr_we, csr_waddr, csr_wdata, mstatus_ie_clear, mstatus_ie_set,
    input  mstatus_ie, mtvec, mepc
  );

  modport slave (
    input  csr_we, csr_waddr, csr_wdata, mstatus_ie_clear, mstatus_ie_set,
    output mstatus_ie, mtvec, mepc
  );
endinterface

// File: rtl/trap_ctrl_vec.sv
// Trap vector computation: base of mtvec, plus 4*cause for interrupts when
// mtvec selects vectored mode. Purely combinational.
module trap_vec
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic            cause_irq,
  input  logic [3:0]      cause_code,
  output logic [XLEN-1:0] redirect_pc
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;

  assign base   = {mtvec[XLEN-1:2], 2'b00};
  assign offset = {{(XLEN-6){1'b0}}, cause_code, 2'b00};

  // Exceptions always land on the base, even in vectored mode.
  assign redirect_pc = ((mtvec[1:0] == MTVEC_VECTORED) && cause_irq) ? base + offset : base;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: owns the CSR write port while writing
// mepc/mcause/mtval, then flushes and redirects; also handles mret.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int IRQ_CODE = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_valid,
  input  logic [3:0]        exc_code,
  input  logic [XLEN-1:0]   exc_pc,
  input  logic [XLEN-1:0]   exc_tval,
  input  logic              irq_pending,
  input  logic              mret_valid,
  input  logic              retire,
  input  logic              wb_csr_we,
  input  logic [11:0]       wb_csr_waddr,
  input  logic [XLEN-1:0]   wb_csr_wdata,
  trap_ctrl_if.master       csr,
  output logic              instret_incr,
  output logic              stall,
  output logic              flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  localparam logic [3:0]      IRQ_CODE4 = 4'(IRQ_CODE);
  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-5){1'b0}}, IRQ_CODE4};

  trap_state_t     state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] cause_reg, cause_next;
  logic [XLEN-1:0] tval_reg, tval_next;

  logic            irq_take;
  logic            in_idle;
  logic            take_exc, take_irq, take_mret, accept;
  logic [XLEN-1:0] vec_pc;

  logic            csr_we_next;
  logic [11:0]     csr_waddr_next;
  logic [XLEN-1:0] csr_wdata_next;
  logic            ie_clear_next, ie_set_next;
  logic            instret_next, stall_next, flush_next, redirect_valid_next;
  logic [XLEN-1:0] redirect_pc_next;

  assign irq_take  = irq_pending & csr.mstatus_ie;
  assign in_idle   = (state_reg == ST_IDLE);
  assign take_exc  = in_idle & exc_valid;
  assign take_irq  = in_idle & ~exc_valid & irq_take;
  assign take_mret = in_idle & ~exc_valid & ~irq_take & mret_valid;
  assign accept    = take_exc | take_irq | take_mret;

  trap_vec #(.XLEN(XLEN)) u_trap_vec (
    .mtvec       (csr.mtvec),
    .cause_irq   (cause_reg[XLEN-1]),
    .cause_code  (cause_reg[3:0]),
    .redirect_pc (vec_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      cause_reg <= '0;
      tval_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cause_reg <= cause_next;
      tval_reg  <= tval_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    pc_next             = pc_reg;
    cause_next          = cause_reg;
    tval_next           = tval_reg;
    csr_we_next         = 1'b0;
    csr_waddr_next      = '0;
    csr_wdata_next      = '0;
    ie_clear_next       = 1'b0;
    ie_set_next         = 1'b0;
    instret_next        = 1'b0;
    stall_next          = 1'b0;
    flush_next          = 1'b0;
    redirect_valid_next = 1'b0;
    redirect_pc_next    = '0;

    case (state_reg)
      ST_IDLE: begin
        stall_next   = accept;
        instret_next = retire & ~exc_valid & ~irq_take;
        if (take_exc) begin
          state_next = ST_W_EPC;
          pc_next    = exc_pc;
          cause_next = {{(XLEN-4){1'b0}}, exc_code};
          tval_next  = exc_tval;
        end else if (take_irq) begin
          state_next = ST_W_EPC;
          pc_next    = exc_pc;
          cause_next = IRQ_CAUSE;
          tval_next  = '0;
        end else if (take_mret) begin
          state_next = ST_MRET;
        end else begin
          csr_we_next    = wb_csr_we;
          csr_waddr_next = wb_csr_waddr;
          csr_wdata_next = wb_csr_wdata;
        end
      end
      ST_W_EPC: begin
        stall_next     = 1'b1;
        csr_we_next    = 1'b1;
        csr_waddr_next = CSR_MEPC_ADDR;
        csr_wdata_next = {pc_reg[XLEN-1:2], 2'b00};
        state_next     = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        stall_next     = 1'b1;
        csr_we_next    = 1'b1;
        csr_waddr_next = CSR_MCAUSE_ADDR;
        csr_wdata_next = cause_reg;
        state_next     = ST_W_TVAL;
      end
      ST_W_TVAL: begin
        stall_next     = 1'b1;
        csr_we_next    = 1'b1;
        csr_waddr_next = CSR_MTVAL_ADDR;
        csr_wdata_next = tval_reg;
        ie_clear_next  = 1'b1;
        state_next     = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall_next          = 1'b1;
        flush_next          = 1'b1;
        redirect_valid_next = 1'b1;
        redirect_pc_next    = vec_pc;
        state_next          = ST_IDLE;
      end
      ST_MRET: begin
        // mepc is read here so a WB write to it in an earlier cycle is seen.
        stall_next          = 1'b1;
        ie_set_next         = 1'b1;
        flush_next          = 1'b1;
        redirect_valid_next = 1'b1;
        redirect_pc_next    = csr.mepc;
        state_next          = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Reset silences every output at once, including the WB passthrough.
    if (rst) begin
      csr_we_next         = 1'b0;
      csr_waddr_next      = '0;
      csr_wdata_next      = '0;
      ie_clear_next       = 1'b0;
      ie_set_next         = 1'b0;
      instret_next        = 1'b0;
      stall_next          = 1'b0;
      flush_next          = 1'b0;
      redirect_valid_next = 1'b0;
      redirect_pc_next    = '0;
    end
  end

  assign csr.csr_we           = csr_we_next;
  assign csr.csr_waddr        = csr_waddr_next;
  assign csr.csr_wdata        = csr_wdata_next;
  assign csr.mstatus_ie_clear = ie_clear_next;
  assign csr.mstatus_ie_set   = ie_set_next;
  assign instret_incr         = instret_next;
  assign stall                = stall_next;
  assign flush                = flush_next;
  assign redirect_valid       = redirect_valid_next;
  assign redirect_pc          = redirect_pc_next;

endmodule
